// File: rtl/alu_rem_out_stage_pkg.sv
// Shared ALU package for the remainder output stage: default result width,
// entry field layout {R, DZF, SF, ZF} and the occupancy encoding.
package alu_rem_out_stage_pkg;

    localparam int ALU_RW      = 5;
    localparam int ALU_FLAG_W  = 3;
    localparam int ALU_ENTRY_W = ALU_RW + ALU_FLAG_W;

    // Bit positions inside one packed entry, MSB side holds R.
    localparam int ENT_ZF_BIT = 0;
    localparam int ENT_SF_BIT = 1;
    localparam int ENT_DZ_BIT = 2;
    localparam int ENT_R_LSB  = 3;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic int entry_w(input int rw);
        return rw + ALU_FLAG_W;
    endfunction

endpackage

// File: rtl/alu_rem_out_stage_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; every output is a register
// loaded from the next-state view of the storage.
module alu_fifo2
    import alu_rem_out_stage_pkg::*;
#(
    parameter int W = ALU_ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         occ_r;
    occ_e         occ_nxt_s;
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic         wr_ptr_nxt_s;
    logic         rd_ptr_nxt_s;
    logic [W-1:0] mem_r     [0:1];
    logic [W-1:0] mem_nxt_s [0:1];
    logic [W-1:0] head_nxt_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [W-1:0] out_data_r;
    logic         push_s;
    logic         pop_s;

    // Next occupancy, pointers, storage and head entry.
    always_comb begin
        push_s = in_valid && in_ready_r;
        pop_s  = out_valid_r && out_ready;

        occ_nxt_s = occ_r;
        case (occ_r)
            OCC_EMPTY: begin
                if (push_s) occ_nxt_s = OCC_ONE;
                else        occ_nxt_s = OCC_EMPTY;
            end
            OCC_ONE: begin
                if (push_s && !pop_s)      occ_nxt_s = OCC_FULL;
                else if (!push_s && pop_s) occ_nxt_s = OCC_EMPTY;
                else                       occ_nxt_s = OCC_ONE;
            end
            OCC_FULL: begin
                if (pop_s) occ_nxt_s = OCC_ONE;
                else       occ_nxt_s = OCC_FULL;
            end
            default: occ_nxt_s = OCC_EMPTY;
        endcase

        wr_ptr_nxt_s = wr_ptr_r ^ push_s;
        rd_ptr_nxt_s = rd_ptr_r ^ pop_s;

        mem_nxt_s[0] = mem_r[0];
        mem_nxt_s[1] = mem_r[1];
        if (push_s) begin
            mem_nxt_s[wr_ptr_r] = in_data;
        end else begin
            mem_nxt_s[wr_ptr_r] = mem_r[wr_ptr_r];
        end

        // Head is looked up after the write so push+pop in ONE forwards the new entry.
        if (occ_nxt_s == OCC_EMPTY) begin
            head_nxt_s = {W{1'b0}};
        end else begin
            head_nxt_s = mem_nxt_s[rd_ptr_nxt_s];
        end
    end

    // Storage, pointers and registered handshake/data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r       <= OCC_EMPTY;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            mem_r[0]    <= {W{1'b0}};
            mem_r[1]    <= {W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
        end else begin
            occ_r       <= occ_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            mem_r[0]    <= mem_nxt_s[0];
            mem_r[1]    <= mem_nxt_s[1];
            in_ready_r  <= (occ_nxt_s != OCC_FULL);
            out_valid_r <= (occ_nxt_s != OCC_EMPTY);
            out_data_r  <= head_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: rtl/alu_rem_out_stage.sv
// Remainder-unit output stage: 2-entry result buffer plus divide-by-zero
// statistics (sticky flag and saturating event counter).
module alu_rem_out_stage
    import alu_rem_out_stage_pkg::*;
#(
    parameter int RW = ALU_RW,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] in_r,
    input  logic          in_dzf,
    input  logic          in_sf,
    input  logic          in_zf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_r,
    output logic          out_dzf,
    output logic          out_sf,
    output logic          out_zf,
    output logic          sticky_dzf,
    output logic [CW-1:0] dz_count,
    input  logic          stat_clr
);

    localparam int EW = entry_w(RW);

    logic [EW-1:0] in_entry_s;
    logic [EW-1:0] out_entry_s;
    logic          dz_accept_s;
    logic          sticky_dzf_r;
    logic [CW-1:0] dz_count_r;

    assign in_entry_s = {in_r, in_dzf, in_sf, in_zf};

    alu_fifo2 #(
        .W (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry_s)
    );

    assign out_r   = out_entry_s[EW-1:ENT_R_LSB];
    assign out_dzf = out_entry_s[ENT_DZ_BIT];
    assign out_sf  = out_entry_s[ENT_SF_BIT];
    assign out_zf  = out_entry_s[ENT_ZF_BIT];

    assign dz_accept_s = in_valid && in_ready && in_dzf;

    // Divide-by-zero statistics; a clear request beats a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_dzf_r <= 1'b0;
            dz_count_r   <= {CW{1'b0}};
        end else if (stat_clr) begin
            sticky_dzf_r <= 1'b0;
            dz_count_r   <= {CW{1'b0}};
        end else if (dz_accept_s) begin
            sticky_dzf_r <= 1'b1;
            if (dz_count_r != {CW{1'b1}}) begin
                dz_count_r <= dz_count_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                dz_count_r <= dz_count_r;
            end
        end else begin
            sticky_dzf_r <= sticky_dzf_r;
            dz_count_r   <= dz_count_r;
        end
    end

    assign sticky_dzf = sticky_dzf_r;
    assign dz_count   = dz_count_r;

endmodule

// File: tb/tb_alu_rem_out_stage.sv
// Self-checking bench for alu_rem_out_stage: directed vector table, multi-cycle
// corner sequences and randomized traffic against a queue-based reference model.
module tb_alu_rem_out_stage;

    localparam int RW  = 5;
    localparam int CW  = 4;
    localparam int CAP = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_r;
    logic          in_dzf;
    logic          in_sf;
    logic          in_zf;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_r;
    logic          out_dzf;
    logic          out_sf;
    logic          out_zf;
    logic          sticky_dzf;
    logic [CW-1:0] dz_count;
    logic          stat_clr;

    alu_rem_out_stage #(.RW(RW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_r       (in_r),
        .in_dzf     (in_dzf),
        .in_sf      (in_sf),
        .in_zf      (in_zf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_dzf    (out_dzf),
        .out_sf     (out_sf),
        .out_zf     (out_zf),
        .sticky_dzf (sticky_dzf),
        .dz_count   (dz_count),
        .stat_clr   (stat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] r;
        logic          d;
        logic          s;
        logic          z;
    } ent_t;

    // Reference model: FIFO contents as a queue plus the statistics.
    ent_t m_q[$];
    int   m_cnt;
    bit   m_sticky;

    int n_cmp;
    int n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_valid"}, out_valid, (m_q.size() > 0));
        chk({tag, ".in_ready"}, in_ready, (m_q.size() < 2));
        if (m_q.size() > 0) begin
            chk({tag, ".out_r"}, out_r, m_q[0].r);
            chk({tag, ".out_flags"}, {out_dzf, out_sf, out_zf}, {m_q[0].d, m_q[0].s, m_q[0].z});
        end
        chk({tag, ".sticky"}, sticky_dzf, m_sticky);
        chk({tag, ".dz_count"}, dz_count, m_cnt);
    endtask

    // One clock: drive inputs (we sit at a negedge), advance model at posedge, check at next negedge.
    task automatic cycle(input logic iv, input logic ordy, input logic [RW-1:0] r,
                         input logic d, input logic s, input logic z, input logic clr,
                         input string tag);
        bit   push;
        bit   pop;
        ent_t e;
        in_valid  = iv;
        out_ready = ordy;
        in_r      = r;
        in_dzf    = d;
        in_sf     = s;
        in_zf     = z;
        stat_clr  = clr;
        push = iv && (m_q.size() < 2);
        pop  = ordy && (m_q.size() > 0);
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            e.r = r; e.d = d; e.s = s; e.z = z;
            m_q.push_back(e);
        end
        if (clr) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else if (push && d) begin
            m_sticky = 1'b1;
            if (m_cnt < CAP) m_cnt++;
        end
        @(negedge clk);
        chk_model(tag);
    endtask

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [RW-1:0] r;
        logic          d;
        logic          s;
        logic          z;
        logic          clr;
        logic          e_ov;
        logic [RW-1:0] e_r;
        logic [2:0]    e_fl;
        logic          e_ir;
        logic          e_st;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vt[10];

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_cnt = 0;
        m_sticky = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_r = '0;
        in_dzf = 1'b0; in_sf = 1'b0; in_zf = 1'b0; stat_clr = 1'b0;

        // Hand-derived expectations after each cycle's edge, starting empty.
        //          iv    ordy  r       d     s     z     clr   ov    out_r   flags   ir    st    cnt
        vt[0] = '{1'b1, 1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  3'b000, 1'b1, 1'b0, 4'd0};
        vt[1] = '{1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'b000, 1'b1, 1'b0, 4'd0};
        vt[2] = '{1'b1, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  3'b100, 1'b1, 1'b1, 4'd1};
        vt[3] = '{1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  3'b100, 1'b0, 1'b1, 4'd1};
        vt[4] = '{1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  3'b100, 1'b0, 1'b1, 4'd1};
        vt[5] = '{1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  3'b010, 1'b1, 1'b1, 4'd1};
        vt[6] = '{1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  3'b001, 1'b1, 1'b1, 4'd1};
        vt[7] = '{1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'b000, 1'b1, 1'b1, 4'd1};
        vt[8] = '{1'b1, 1'b1, 5'h1f, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'h1f, 3'b110, 1'b1, 1'b0, 4'd0};
        vt[9] = '{1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'b000, 1'b1, 1'b0, 4'd0};

        repeat (2) @(negedge clk);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_r", out_r, 5'd0);
        chk("rst.flags", {out_dzf, out_sf, out_zf}, 3'b000);
        chk("rst.sticky", sticky_dzf, 1'b0);
        chk("rst.dz_count", dz_count, 4'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].iv, vt[i].ordy, vt[i].r, vt[i].d, vt[i].s, vt[i].z, vt[i].clr,
                  $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.t_ov", i), out_valid, vt[i].e_ov);
            chk($sformatf("vec%0d.t_ir", i), in_ready, vt[i].e_ir);
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d.t_r", i), out_r, vt[i].e_r);
                chk($sformatf("vec%0d.t_fl", i), {out_dzf, out_sf, out_zf}, vt[i].e_fl);
            end
            chk($sformatf("vec%0d.t_st", i), sticky_dzf, vt[i].e_st);
            chk($sformatf("vec%0d.t_cnt", i), dz_count, vt[i].e_cnt);
        end

        // Twenty divide-by-zero results drive the counter into saturation.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, "dzsat");
        chk("dzsat.count", dz_count, 4'd15);
        chk("dzsat.sticky", sticky_dzf, 1'b1);
        cycle(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "drain");

        // Fill to FULL, then assert reset mid-cycle.
        cycle(1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, "fill0");
        cycle(1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, "fill1");
        chk("full.in_ready", in_ready, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 1'b0);
        chk("arst.in_ready", in_ready, 1'b1);
        chk("arst.out_r", out_r, 5'd0);
        chk("arst.dz_count", dz_count, 4'd0);
        chk("arst.sticky", sticky_dzf, 1'b0);
        m_q.delete();
        m_cnt = 0;
        m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "postrst");
        cycle(1'b1, 1'b0, 5'h15, 1'b0, 1'b0, 1'b1, 1'b0, "postrst_push");
        chk("postrst.r", out_r, 5'h15);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  RW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
